call_stack: RTL and testbench
=============================

Name: call_stack

Overview:
- LIFO return-address stack for the program sequencer.
- The sequencer pushes a 20-bit frame on CALL or interrupt entry. The frame is {PC[15:0], V, N, Z, C}.
- The sequencer pops the frame on RET/RETI.
- The top-of-stack frame is always visible on DO, so the sequencer can read it in the same cycle it requests the pop.

Parameters:
- WIDTH, 20, frame width in bits.
- DEPTH, 16, number of frames (power of two, >=2).
- PTR_W, $clog2(DEPTH)+1, stack-pointer width (derived; not overridden).

Ports:
- CLK2  input  1  stack clock; all state updates on rising edge.
- RESET  input  1  synchronous active-high reset, sampled on rising CLK2.
- DI  input  WIDTH  frame to push.
- ENA  input  1  push request, level-sampled on each rising CLK2.
- RTS  input  1  pop request, level-sampled on each rising CLK2.
- DO  output  WIDTH  current top-of-stack frame (combinational from storage and pointer).
- EMPTY  output  1  high when the stack holds 0 frames.
- FULL  output  1  high when the stack holds DEPTH frames.

Behaviour:
- Storage is mem[0..DEPTH-1] of WIDTH bits. SP (PTR_W bits) counts the stored frames, range 0..DEPTH.
- DO = mem[SP-1] when SP>0; DO = 0 when SP=0. DO is not registered: it changes immediately after the edge that modifies SP or the top entry.
- EMPTY = (SP==0). FULL = (SP==DEPTH).
- Reset (RESET=1 at rising CLK2): SP<=0, so DO=0, EMPTY=1, FULL=0. Memory contents are don't-care and need not be cleared. RESET has priority over ENA and RTS.
- Each rising CLK2 with RESET=0 is decoded as follows:
  - ENA=0, RTS=0: hold.
  - ENA=1, RTS=0, not FULL: mem[SP]<=DI, SP<=SP+1.
  - ENA=1, RTS=0, FULL: push is dropped, no state change (overflow is silent).
  - ENA=0, RTS=1, not EMPTY: SP<=SP-1; the popped frame was on DO before the edge.
  - ENA=0, RTS=1, EMPTY: pop ignored, SP stays 0, DO stays 0.
  - ENA=1, RTS=1, not EMPTY: replace top: mem[SP-1]<=DI, SP unchanged.
  - ENA=1, RTS=1, EMPTY: behaves as a push.
- Latency:
  - A pushed frame appears on DO after the same edge (0 extra cycles).
  - After a pop, DO shows the next-older frame after that edge.
- ENA/RTS are level-sensitive. A request held high for N CLK2 edges performs N operations; the requester is responsible for deasserting.
- DI is sampled only on edges where a write occurs.
- Frame content is opaque to the block. The bit layout (PC in [19:4]; V, N, Z, C in [3:0]) is a sequencer convention only.
- No wrap-around: SP saturates at 0 and DEPTH.

Test Plan:
- Reset: assert RESET for 1 edge with ENA=1 and DI=20'hABCDE -> SP=0, DO=0, EMPTY=1, FULL=0; the push is not performed.
- Push/pop order: push 20'h00101, 20'h00202, 20'h00303 on consecutive edges -> after each edge DO equals the frame just pushed. Then pop 3 times -> DO goes to 00202, 00101, 0; EMPTY=1 after the third pop.
- Same-cycle read-before-pop: with top=20'h12345, assert RTS -> DO=12345 before the edge. After the edge DO shows the previous entry.
- Underflow: pop on an empty stack for 2 edges -> DO=0, EMPTY=1, SP unchanged. A following push of 20'h0000F -> DO=0000F.
- Overflow: push DEPTH frames k=1..DEPTH -> FULL=1, DO=DEPTH. Push 20'hFFFFF -> ignored, DO still DEPTH. Pop DEPTH times -> values DEPTH..1 returned in order.
- Simultaneous ENA+RTS: stack holds 00011, 00022; assert both with DI=00099 -> DO=00099 and SP stays 2. Then pop -> DO=00011.

Source files
------------

// File: rtl/call_stack.sv
// call_stack: LIFO return-address stack for the program sequencer.
// Holds up to DEPTH frames. The top frame is presented combinationally on DO,
// so the sequencer can read the frame in the same cycle it requests the pop.
module call_stack #(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK2,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DI,
    input  logic             ENA,
    input  logic             RTS,
    output logic [WIDTH-1:0] DO,
    output logic             EMPTY,
    output logic             FULL
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Frame storage; contents are never cleared because a slot is only read
    // after it has been written.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Count of stored frames, 0..DEPTH.
    logic [PTR_W-1:0] r_sp;

    logic [PTR_W-1:0]  w_sp_nxt;
    logic [PTR_W-1:0]  w_sp_m1;
    logic [ADDR_W-1:0] w_top_idx;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_we;
    logic              w_empty;
    logic              w_full;

    assign w_empty   = (r_sp == {PTR_W{1'b0}});
    assign w_full    = (r_sp == PTR_W'(DEPTH));
    assign w_sp_m1   = r_sp - PTR_W'(1);
    assign w_top_idx = w_sp_m1[ADDR_W-1:0];

    assign EMPTY = w_empty;
    assign FULL  = w_full;

    // Top-of-stack view: zero when empty, otherwise the newest frame.
    always_comb begin
        if (w_empty) begin
            DO = {WIDTH{1'b0}};
        end else begin
            DO = r_mem[w_top_idx];
        end
    end

    // Decode push/pop/replace requests into a write strobe, write slot and next pointer.
    always_comb begin
        w_we     = 1'b0;
        w_waddr  = r_sp[ADDR_W-1:0];
        w_sp_nxt = r_sp;
        case ({ENA, RTS})
            2'b10: begin
                // Push; silently dropped when full.
                if (!w_full) begin
                    w_we     = 1'b1;
                    w_waddr  = r_sp[ADDR_W-1:0];
                    w_sp_nxt = r_sp + PTR_W'(1);
                end else begin
                    w_we     = 1'b0;
                    w_sp_nxt = r_sp;
                end
            end
            2'b01: begin
                // Pop; ignored when empty so the pointer never underflows.
                if (!w_empty) begin
                    w_sp_nxt = w_sp_m1;
                end else begin
                    w_sp_nxt = r_sp;
                end
            end
            2'b11: begin
                // Replace the top frame; on an empty stack this is a plain push.
                if (w_empty) begin
                    w_we     = 1'b1;
                    w_waddr  = {ADDR_W{1'b0}};
                    w_sp_nxt = PTR_W'(1);
                end else begin
                    w_we     = 1'b1;
                    w_waddr  = w_top_idx;
                    w_sp_nxt = r_sp;
                end
            end
            default: begin
                w_we     = 1'b0;
                w_sp_nxt = r_sp;
            end
        endcase
    end

    // Stack pointer update; reset wins over any request.
    always_ff @(posedge CLK2) begin
        if (RESET) begin
            r_sp <= {PTR_W{1'b0}};
        end else begin
            r_sp <= w_sp_nxt;
        end
    end

    // Frame write; suppressed during reset so a reset-cycle push leaves no trace.
    always_ff @(posedge CLK2) begin
        if (w_we && !RESET) begin
            r_mem[w_waddr] <= DI;
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed self-checking bench for call_stack.
module tb_call_stack;

    localparam int WIDTH = 20;
    localparam int DEPTH = 16;

    logic             CLK2;
    logic             RESET;
    logic [WIDTH-1:0] DI;
    logic             ENA;
    logic             RTS;
    logic [WIDTH-1:0] DO;
    logic             EMPTY;
    logic             FULL;

    int n_tests;
    int n_fail;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK2  (CLK2),
        .RESET (RESET),
        .DI    (DI),
        .ENA   (ENA),
        .RTS   (RTS),
        .DO    (DO),
        .EMPTY (EMPTY),
        .FULL  (FULL)
    );

    // Free-running stack clock.
    initial CLK2 = 1'b0;
    always #5 CLK2 = ~CLK2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs on the falling edge, away from the active edge.
    task automatic drive(input logic rst, input logic e, input logic r, input logic [WIDTH-1:0] d);
        @(negedge CLK2);
        RESET = rst;
        ENA   = e;
        RTS   = r;
        DI    = d;
        #1;
    endtask

    // Let one rising edge happen, then settle before sampling.
    task automatic tick();
        @(posedge CLK2);
        #1;
    endtask

    task automatic step(input logic e, input logic r, input logic [WIDTH-1:0] d);
        drive(1'b0, e, r, d);
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RESET   = 1'b1;
        ENA     = 1'b0;
        RTS     = 1'b0;
        DI      = 20'h00000;

        // Reset with a concurrent push request: push must not happen.
        drive(1'b1, 1'b1, 1'b0, 20'hABCDE);
        tick();
        chk("rst_do", 32'(DO), 32'h0);
        chk("rst_empty", 32'(EMPTY), 32'h1);
        chk("rst_full", 32'(FULL), 32'h0);
        step(1'b0, 1'b0, 20'h00000);
        chk("rst_hold_do", 32'(DO), 32'h0);
        chk("rst_hold_empty", 32'(EMPTY), 32'h1);

        // Push three frames, then pop them back in reverse order.
        step(1'b1, 1'b0, 20'h00101);
        chk("push1_do", 32'(DO), 32'h00101);
        chk("push1_empty", 32'(EMPTY), 32'h0);
        step(1'b1, 1'b0, 20'h00202);
        chk("push2_do", 32'(DO), 32'h00202);
        step(1'b1, 1'b0, 20'h00303);
        chk("push3_do", 32'(DO), 32'h00303);
        step(1'b0, 1'b1, 20'h00000);
        chk("pop1_do", 32'(DO), 32'h00202);
        step(1'b0, 1'b1, 20'h00000);
        chk("pop2_do", 32'(DO), 32'h00101);
        step(1'b0, 1'b1, 20'h00000);
        chk("pop3_do", 32'(DO), 32'h0);
        chk("pop3_empty", 32'(EMPTY), 32'h1);

        // Read-before-pop: top frame visible while the pop is requested.
        step(1'b1, 1'b0, 20'h00777);
        step(1'b1, 1'b0, 20'h12345);
        drive(1'b0, 1'b0, 1'b1, 20'h00000);
        chk("rbp_before", 32'(DO), 32'h12345);
        tick();
        chk("rbp_after", 32'(DO), 32'h00777);
        step(1'b0, 1'b1, 20'h00000);
        chk("rbp_drain_empty", 32'(EMPTY), 32'h1);

        // Underflow: two pops on an empty stack, then a push.
        step(1'b0, 1'b1, 20'h00000);
        step(1'b0, 1'b1, 20'h00000);
        chk("uflow_do", 32'(DO), 32'h0);
        chk("uflow_empty", 32'(EMPTY), 32'h1);
        step(1'b1, 1'b0, 20'h0000F);
        chk("uflow_push_do", 32'(DO), 32'h0000F);
        chk("uflow_push_empty", 32'(EMPTY), 32'h0);
        step(1'b0, 1'b1, 20'h00000);
        chk("uflow_pop_empty", 32'(EMPTY), 32'h1);

        // Overflow: fill with 1..DEPTH, push once more, then drain.
        for (int k = 1; k <= DEPTH; k++) begin
            step(1'b1, 1'b0, WIDTH'(k));
            chk("fill_do", 32'(DO), 32'(k));
            chk("fill_full", 32'(FULL), (k == DEPTH) ? 32'h1 : 32'h0);
        end
        step(1'b1, 1'b0, 20'hFFFFF);
        chk("oflow_do", 32'(DO), 32'(DEPTH));
        chk("oflow_full", 32'(FULL), 32'h1);
        for (int k = DEPTH; k >= 1; k--) begin
            drive(1'b0, 1'b0, 1'b1, 20'h00000);
            chk("drain_do", 32'(DO), 32'(k));
            tick();
        end
        chk("drain_do_end", 32'(DO), 32'h0);
        chk("drain_empty", 32'(EMPTY), 32'h1);
        chk("drain_full", 32'(FULL), 32'h0);

        // Simultaneous push+pop replaces the top frame.
        step(1'b1, 1'b0, 20'h00011);
        step(1'b1, 1'b0, 20'h00022);
        step(1'b1, 1'b1, 20'h00099);
        chk("repl_do", 32'(DO), 32'h00099);
        step(1'b0, 1'b1, 20'h00000);
        chk("repl_pop_do", 32'(DO), 32'h00011);
        step(1'b0, 1'b1, 20'h00000);
        chk("repl_pop2_empty", 32'(EMPTY), 32'h1);

        // Push+pop on an empty stack acts as a push.
        step(1'b1, 1'b1, 20'h00055);
        chk("repl_empty_do", 32'(DO), 32'h00055);
        chk("repl_empty_empty", 32'(EMPTY), 32'h0);

        // Reset with a pending pop clears the stack.
        step(1'b1, 1'b0, 20'h00066);
        drive(1'b1, 1'b0, 1'b1, 20'h00000);
        tick();
        chk("rst2_do", 32'(DO), 32'h0);
        chk("rst2_empty", 32'(EMPTY), 32'h1);
        step(1'b0, 1'b0, 20'h00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
